// File: rtl/conv1.sv
// rtl/conv1.sv - 3x3 valid convolution of one 8-bit image against CHAN signed kernels, ReLU.
// One output pixel per cycle, channels in sequence, with a one-cycle strobe per finished channel.
module conv1 #(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int IN1_H  = 16,
  parameter int IN1_W  = 15,
  parameter int OUT1_H = IN1_H - K_H + 1,
  parameter int OUT1_W = IN1_W - K_W + 1,
  parameter int CHAN   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trigger,
  input  logic        [7:0]  in_img   [IN1_H][IN1_W],
  input  logic signed [7:0]  w_conv1  [K_H][K_W][CHAN],
  output logic signed [23:0] out_buff [OUT1_H][OUT1_W],
  output logic               out_valid,
  output logic        [3:0]  out_chan
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_R  = 4'(OUT1_H - 1);
  localparam logic [3:0] LAST_C  = 4'(OUT1_W - 1);
  localparam logic [3:0] LAST_CH = 4'(CHAN - 1);

  state_t             state;
  logic        [3:0]  ch;
  logic        [3:0]  r;
  logic        [3:0]  c;
  logic signed [16:0] prod;
  logic signed [23:0] sum;
  logic signed [23:0] relu;

  // Window sum for the pixel addressed by (r, c) on the current channel.
  always_comb begin
    prod = '0;
    sum  = '0;
    for (int i = 0; i < K_H; i++) begin
      for (int j = 0; j < K_W; j++) begin
        prod = 17'($signed({1'b0, in_img[int'(r) + i][int'(c) + j]})) * 17'(w_conv1[i][j][ch]);
        sum  = sum + 24'(prod);
      end
    end
    relu = sum[23] ? '0 : sum;
  end

  assign out_chan = ch;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      ch        <= '0;
      r         <= '0;
      c         <= '0;
      for (int a = 0; a < OUT1_H; a++) begin
        for (int b = 0; b < OUT1_W; b++) begin
          out_buff[a][b] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (trigger) begin
            state <= RUN;
            ch    <= '0;
            r     <= '0;
            c     <= '0;
          end
        end
        RUN: begin
          out_buff[r][c] <= relu;
          if (c == LAST_C) begin
            c <= '0;
            if (r == LAST_R) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              r <= r + 4'd1;
            end
          end else begin
            c <= c + 4'd1;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          r         <= '0;
          c         <= '0;
          // ch is left at the last channel when returning to IDLE.
          if (ch < LAST_CH) begin
            ch    <= ch + 4'd1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv1.sv
// tb/tb_conv1.sv - self-checking bench for conv1 against an arithmetic convolution model.
module tb_conv1;
  localparam int K_H = 3, K_W = 3, IN1_H = 16, IN1_W = 15;
  localparam int OUT1_H = 14, OUT1_W = 13, CHAN = 10, PER_CH = 183;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               trigger = 1'b0;
  logic        [7:0]  img      [IN1_H][IN1_W];
  logic signed [7:0]  w        [K_H][K_W][CHAN];
  logic signed [23:0] out_buff [OUT1_H][OUT1_W];
  logic               out_valid;
  logic        [3:0]  out_chan;

  int checks = 0;
  int failures = 0;
  int saved [CHAN][OUT1_H][OUT1_W];

  typedef struct {
    int px;
    int wt;
    int exp;
  } vec_t;

  conv1 dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .in_img(img), .w_conv1(w),
    .out_buff(out_buff), .out_valid(out_valid), .out_chan(out_chan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int ref_val(int ch, int r, int c);
    int s = 0;
    for (int i = 0; i < K_H; i++)
      for (int j = 0; j < K_W; j++)
        s += int'(img[r + i][c + j]) * int'(w[i][j][ch]);
    return (s < 0) ? 0 : s;
  endfunction

  task automatic fill_uniform(input int px, input int wt);
    for (int a = 0; a < IN1_H; a++) for (int b = 0; b < IN1_W; b++) img[a][b] = 8'(px);
    for (int i = 0; i < K_H; i++) for (int j = 0; j < K_W; j++)
      for (int k = 0; k < CHAN; k++) w[i][j][k] = 8'(wt);
  endtask

  task automatic fill_random();
    for (int a = 0; a < IN1_H; a++) for (int b = 0; b < IN1_W; b++) img[a][b] = 8'($urandom_range(0, 255));
    for (int i = 0; i < K_H; i++) for (int j = 0; j < K_W; j++)
      for (int k = 0; k < CHAN; k++) w[i][j][k] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_cleared(input string name);
    int nz = 0;
    for (int a = 0; a < OUT1_H; a++) for (int b = 0; b < OUT1_W; b++)
      if (out_buff[a][b] !== 24'sd0) nz++;
    chk({name, "_buff_nonzero"}, nz, 0);
    chk({name, "_valid"}, int'(out_valid), 0);
    chk({name, "_chan"}, int'(out_chan), 0);
  endtask

  // mode: 0 = model, 1 = uniform expected value uval, 2 = model plus impulse corner.
  // save: 1 store results, 2 compare with stored results.
  task automatic run_check(input string name, input int mode, input int uval,
                           input int retrig_at, input int save);
    int strobes = 0;
    int last_cyc = -1;
    int prev_v = 0;
    int bad;
    int first_bad;
    int exp;
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
    for (int cyc = 0; cyc < CHAN * PER_CH + 20; cyc++) begin
      @(negedge clk);
      trigger = (cyc == retrig_at) ? 1'b1 : 1'b0;
      if (out_valid === 1'b1) begin
        chk({name, "_rising"}, prev_v, 0);
        chk({name, "_chan"}, int'(out_chan), strobes);
        if (strobes == 0) chk({name, "_latency"}, cyc, PER_CH - 2);
        else chk({name, "_spacing"}, cyc - last_cyc, PER_CH);
        bad = 0;
        first_bad = -1;
        for (int a = 0; a < OUT1_H; a++) begin
          for (int b = 0; b < OUT1_W; b++) begin
            exp = (mode == 1) ? uval : ref_val(strobes, a, b);
            if (save == 2) exp = saved[strobes][a][b];
            if (save == 1) saved[strobes][a][b] = int'(out_buff[a][b]);
            if (int'(out_buff[a][b]) != exp) begin
              bad++;
              if (first_bad < 0) begin
                first_bad = a * OUT1_W + b;
                $display("first difference %s ch%0d [%0d][%0d]: got %0d expected %0d",
                         name, strobes, a, b, int'(out_buff[a][b]), exp);
              end
            end
          end
        end
        chk({name, "_buff_errors"}, bad, 0);
        if (mode == 2) chk({name, "_impulse00"}, int'(out_buff[0][0]), strobes + 1);
        last_cyc = cyc;
        strobes++;
      end
      prev_v = int'(out_valid);
    end
    trigger = 1'b0;
    chk({name, "_strobes"}, strobes, CHAN);
    chk({name, "_idle_chan"}, int'(out_chan), CHAN - 1);
    chk({name, "_idle_valid"}, int'(out_valid), 0);
  endtask

  initial begin
    vec_t vecs [4];
    int seen;
    vecs[0] = '{px: 255, wt: -128, exp: 0};
    vecs[1] = '{px: 255, wt: 127,  exp: 291465};
    vecs[2] = '{px: 1,   wt: -1,   exp: 0};
    vecs[3] = '{px: 100, wt: 3,    exp: 2700};

    fill_random();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_cleared("reset");
    seen = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    chk("no_trigger_strobes", seen, 0);
    check_cleared("no_trigger");

    run_check("random", 0, 0, -1, 1);
    run_check("rerun", 0, 0, -1, 2);
    run_check("retrigger", 0, 0, 500, 2);

    for (int v = 0; v < 4; v++) begin
      fill_uniform(vecs[v].px, vecs[v].wt);
      run_check($sformatf("uniform%0d", v), 1, vecs[v].exp, -1, 0);
    end

    fill_random();
    for (int a = 0; a < IN1_H; a++) for (int b = 0; b < IN1_W; b++) img[a][b] = 8'd0;
    img[0][0] = 8'd1;
    for (int k = 0; k < CHAN; k++) w[0][0][k] = 8'(k + 1);
    run_check("impulse", 2, 0, -1, 0);

    fill_random();
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
    repeat (300) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check_cleared("midrun_reset");
    seen = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    chk("after_reset_strobes", seen, 0);
    run_check("post_reset", 0, 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
